// File: rtl/fa_pkg.sv
// Shared types and defaults for the bit-serial full-adder initiator.
package fa_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} fa_ser_state_t;

  localparam int unsigned FA_SER_W_DEF = 8;

endpackage

// File: rtl/fa_if.sv
// One-bit full-adder link: initiator drives a/b/c, combinational peer returns sum/carry.
interface fa;

  logic a;
  logic b;
  logic c;
  logic sum;
  logic carry;

  modport tb_mp  (output a, b, c, input  sum, carry);
  modport dut_mp (input  a, b, c, output sum, carry);

endinterface

// File: rtl/full_adder.sv
// Combinational one-bit full adder sitting on the dut_mp end of the fa link.
module full_adder (
  fa.dut_mp p
);

  always_comb begin
    p.sum   = p.a ^ p.b ^ p.c;
    p.carry = (p.a & p.b) | (p.a & p.c) | (p.b & p.c);
  end

endmodule

// File: rtl/fa_serial_initiator.sv
// Bit-serial W-bit adder controller driving a full-adder peer LSB-first.
// Optional FA_SELF_CHECK_EN builds an expected-sum register and sticky mismatch flag.
module fa_serial_initiator
  import fa_pkg::*;
#(
  parameter int unsigned W = FA_SER_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         cout,
  output logic         mismatch,
  fa.tb_mp             m
);

  localparam int unsigned CW = $clog2(W) + 1;

  fa_ser_state_t state_q, state_d;
  logic [W-1:0]  sh_a_q, sh_a_d;
  logic [W-1:0]  sh_b_q, sh_b_d;
  logic [W-1:0]  res_q, res_d;
  logic          cy_q, cy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fin;

  // Peer drive depends on registered state only, keeping the sum/carry path loop-free.
  always_comb begin
    m.a = 1'b0;
    m.b = 1'b0;
    m.c = 1'b0;
    if (state_q == RUN) begin
      m.a = sh_a_q[0];
      m.b = sh_b_q[0];
      m.c = cy_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    sh_a_d    = sh_a_q;
    sh_b_d    = sh_b_q;
    res_d     = res_q;
    cy_d      = cy_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    fin       = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          sh_a_d  = op_a;
          sh_b_d  = op_b;
          cy_d    = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d  = {m.sum, res_q[W-1:1]};
        cy_d   = m.carry;
        sh_a_d = sh_a_q >> 1;
        sh_b_d = sh_b_q >> 1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(W - 1)) begin
          fin     = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sh_a_q  <= '0;
      sh_b_q  <= '0;
      res_q   <= '0;
      cy_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_a_q  <= sh_a_d;
      sh_b_q  <= sh_b_d;
      res_q   <= res_d;
      cy_q    <= cy_d;
      cnt_q   <= cnt_d;
    end
  end

  assign result = res_q;
  assign cout   = cy_q;

`ifdef FA_SELF_CHECK_EN
  logic [W:0] exp_q, exp_d;
  logic       mismatch_q, mismatch_d;

  // Compare against the value about to be registered so the flag lands with DONE.
  always_comb begin
    exp_d      = exp_q;
    mismatch_d = mismatch_q;
    if (state_q == IDLE && in_valid)
      exp_d = {1'b0, op_a} + {1'b0, op_b} + {{W{1'b0}}, cin};
    if (fin && ({cy_d, res_d} != exp_q))
      mismatch_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q      <= '0;
      mismatch_q <= 1'b0;
    end else begin
      exp_q      <= exp_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign mismatch = mismatch_q;
`else
  assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_fa_serial_initiator.sv
// Scoreboard bench for fa_serial_initiator with a full_adder peer on the fa link.
module tb_fa_serial_initiator;
  import fa_pkg::*;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         cout;
  logic         mismatch;
  logic         inv_sum;
  logic         exp_mis;

  int unsigned  n_checks = 0;
  int unsigned  n_errors = 0;
  logic [W:0]   sb_q[$];

  fa f_dut ();
  fa f_peer ();

  // Peer outputs pass through an optional sum inversion before reaching the initiator.
  assign f_peer.a    = f_dut.a;
  assign f_peer.b    = f_dut.b;
  assign f_peer.c    = f_dut.c;
  assign f_dut.sum   = f_peer.sum ^ inv_sum;
  assign f_dut.carry = f_peer.carry;

  full_adder u_peer (.p(f_peer.dut_mp));

  fa_serial_initiator #(.W(W)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .mismatch  (mismatch),
    .m         (f_dut.tb_mp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic ci, input logic inv);
    logic [W-1:0] s;
    logic         c;
    if (!inv) return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    c = ci;
    for (int unsigned i = 0; i < W; i++) begin
      s[i] = ~(a[i] ^ b[i] ^ c);
      c    = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
    end
    return {c, s};
  endfunction

  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    chk("idle_in_ready", in_ready, 1);
    op_a     = a;
    op_b     = b;
    cin      = ci;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                        input int unsigned hold);
    int unsigned lat;
    logic        rdy_bad;
    logic [W:0]  e;
    sb_q.push_back(model(a, b, ci, inv_sum));
    accept(a, b, ci);
    lat     = 0;
    rdy_bad = 1'b0;
    while (!out_valid && lat < W + 4) begin
      if (in_ready) rdy_bad = 1'b1;
      @(negedge clk);
      lat++;
    end
    chk("run_in_ready_low", rdy_bad, 0);
    chk("latency", lat, W);
    if (!out_valid) begin
      void'(sb_q.pop_front());
      return;
    end
    for (int unsigned i = 0; i < hold; i++) begin
      in_valid = (i == 1);
      op_a     = 8'h11;
      op_b     = 8'h22;
      chk("hold_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_result", {cout, result}, sb_q[0]);
      @(negedge clk);
    end
    in_valid = 1'b0;
    e = sb_q.pop_front();
    chk("result", result, e[W-1:0]);
    chk("cout", cout, e[W]);
    chk("mismatch", mismatch, exp_mis);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("back_idle_ready", in_ready, 1);
    chk("back_idle_valid", out_valid, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic ov_seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_a      = '0;
    op_b      = '0;
    cin       = 1'b0;
    inv_sum   = 1'b0;
    exp_mis   = 1'b0;
    do_reset();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_cout", cout, 0);
    chk("rst_mismatch", mismatch, 0);
    chk("rst_abc", {f_dut.a, f_dut.b, f_dut.c}, 0);

    run_op(8'h00, 8'h00, 1'b0, 0);
    run_op(8'hFF, 8'h01, 1'b0, 0);
    run_op(8'hA5, 8'h5A, 1'b1, 0);
    run_op(8'hC3, 8'h81, 1'b1, 5);

    // Abort in the third RUN cycle.
    accept(8'h77, 8'h19, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_abc", {f_dut.a, f_dut.b, f_dut.c}, 0);
    ov_seen = 1'b0;
    for (int unsigned i = 0; i < W + 4; i++) begin
      if (out_valid) ov_seen = 1'b1;
      @(negedge clk);
    end
    chk("abort_no_valid", ov_seen, 0);

    run_op(8'h3C, 8'h0F, 1'b0, 0);
    for (int unsigned i = 0; i < 6; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), i % 3);

`ifdef FA_SELF_CHECK_EN
    inv_sum = 1'b1;
    exp_mis = 1'b1;
    run_op(8'h3C, 8'h0F, 1'b0, 0);
    inv_sum = 1'b0;
    run_op(8'h12, 8'h34, 1'b0, 0);
    do_reset();
    exp_mis = 1'b0;
    chk("mismatch_cleared", mismatch, 0);
    run_op(8'h3C, 8'h0F, 1'b0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
